// File: rtl/lsu_axi_master.sv
// Load/store unit AXI-lite master: one outstanding load or store, lane-aligned
// address/strobe/data generation and sign/zero extension of load results.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              sram_read_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [7:0]        axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  input  logic [1:0]        axi_bresp
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              rw_q, rw_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              aw_fin, w_fin;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = |off;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    lane_strb = base << off;
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    extend_load = uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
      2'd1:    extend_load = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: extend_load = word;
    endcase
  endfunction

  // A write channel counts as finished if it completed earlier or handshakes now.
  assign aw_fin = aw_done_q || (awvalid_q && axi_awready);
  assign w_fin  = w_done_q  || (wvalid_q  && axi_wready);

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    rw_d         = rw_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          off_d       = req_addr[1:0];
          size_d      = req_size;
          uns_d       = req_unsigned;
          if (!req_load && !req_store) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
          end else if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_load) begin
            state_d    = RD_ADDR;
            araddr_d   = {req_addr[ADDR_W-1:2], 2'b00};
            arvalid_d  = 1'b1;
            mem_read_d = 1'b1;
            rw_d       = 1'b0;
          end else begin
            state_d     = WR_REQ;
            awaddr_d    = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d     = req_wdata << {req_addr[1:0], 3'b000};
            wstrb_d     = {4'b0000, lane_strb(req_size, req_addr[1:0])};
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            mem_write_d = 1'b1;
            rw_d        = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi_rvalid) begin
          rready_d     = 1'b0;
          mem_read_d   = 1'b0;
          resp_rdata_d = extend_load(axi_rdata, off_q, size_q, uns_q);
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      WR_REQ: begin
        if (aw_fin) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fin) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi_bvalid) begin
          bready_d     = 1'b0;
          mem_write_d  = 1'b0;
          rw_d         = 1'b0;
          resp_err_d   = (axi_bresp != 2'b00);
          resp_rdata_d = '0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      rw_q         <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      rw_q         <= rw_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_err        = resp_err_q;
  assign sram_read_write = rw_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign axi_araddr      = araddr_q;
  assign axi_arvalid     = arvalid_q;
  assign axi_rready      = rready_q;
  assign axi_awaddr      = awaddr_q;
  assign axi_awvalid     = awvalid_q;
  assign axi_wdata       = wdata_q;
  assign axi_wstrb       = wstrb_q;
  assign axi_wvalid      = wvalid_q;
  assign axi_bready      = bready_q;

endmodule
